// File: rtl/dll_tx_fc_credit_gate.sv
// -----------------------------------------------------------------------------
// dll_tx_fc_credit_gate
//
// Transmit-side flow-control credit gate. It tracks the link partner's
// advertised credit limits (CL) per FC type from the decoded UpdateFC stream,
// and the credits consumed (CC) by granted TLPs. A TLP request is granted only
// when both header and data credit are sufficient for its type.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   updatefc_i        one-cycle strobe, valid decoded UpdateFC
//   fc_type_i         00=P, 01=NP, 10=CPL, 11 ignored
//   hdr_credit_i      advertised header credit limit (mod 64)
//   data_credit_i     advertised data credit limit (mod 4096)
//   tlp_req_i         TLP waiting for grant
//   tlp_type_i        00=P, 01=NP, 10=CPL, 11=illegal
//   tlp_has_data_i    TLP carries payload
//   tlp_len_i         payload length in DW, 0 means 1024
//   tlp_gnt_o         one-cycle grant, credits consumed on the same edge
//   tlp_err_o         one-cycle pulse, illegal TLP type rejected
//   fc_init_o         bit t set once type t has seen its first UpdateFC
// -----------------------------------------------------------------------------
module dll_tx_fc_credit_gate (
    input  logic        clk,
    input  logic        rst,
    input  logic        updatefc_i,
    input  logic [1:0]  fc_type_i,
    input  logic [5:0]  hdr_credit_i,
    input  logic [11:0] data_credit_i,
    input  logic        tlp_req_i,
    input  logic [1:0]  tlp_type_i,
    input  logic        tlp_has_data_i,
    input  logic [9:0]  tlp_len_i,
    output logic        tlp_gnt_o,
    output logic        tlp_err_o,
    output logic [2:0]  fc_init_o
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t      state_reg, state_next;
    logic        gnt_reg, gnt_next;
    logic        err_reg, err_next;

    logic [2:0]  init_vec;
    logic [2:0]  suff;
    logic [3:0]  suff_all;
    logic [2:0]  consume;

    logic [10:0] len_ext;
    logic [10:0] len_round;
    logic [10:0] len_div;
    logic [11:0] req_d;

    // Data credits are 4-DW units: ceil(len/4), with len=0 meaning 1024 DW.
    assign len_ext   = (tlp_len_i == 10'd0) ? 11'd1024 : {1'b0, tlp_len_i};
    assign len_round = len_ext + 11'd3;
    assign len_div   = len_round >> 2;
    assign req_d     = tlp_has_data_i ? {1'b0, len_div} : 12'd0;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_type
            logic        init_reg;
            logic        inf_h_reg, inf_d_reg;
            logic [5:0]  cl_h_reg, cc_h_reg;
            logic [11:0] cl_d_reg, cc_d_reg;
            logic [5:0]  diff_h;
            logic [11:0] diff_d;
            logic        upd_hit;

            assign upd_hit = updatefc_i && (fc_type_i == 2'(gi));

            // Modular distance between limit and post-grant consumption; values
            // in the upper half of the ring are treated as negative (overdraw).
            assign diff_h = cl_h_reg - (cc_h_reg + 6'd1);
            assign diff_d = cl_d_reg - (cc_d_reg + req_d);

            assign suff[gi] = init_reg
                            && (inf_h_reg || (diff_h <= 6'd32))
                            && (inf_d_reg || (diff_d <= 12'd2048));

            assign consume[gi]  = gnt_next && (tlp_type_i == 2'(gi));
            assign init_vec[gi] = init_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    init_reg  <= 1'b0;
                    inf_h_reg <= 1'b0;
                    inf_d_reg <= 1'b0;
                    cl_h_reg  <= 6'd0;
                    cl_d_reg  <= 12'd0;
                    cc_h_reg  <= 6'd0;
                    cc_d_reg  <= 12'd0;
                end else begin
                    if (upd_hit) begin
                        if (!init_reg) begin
                            // First advertisement fixes infinite status for good.
                            init_reg  <= 1'b1;
                            cl_h_reg  <= hdr_credit_i;
                            cl_d_reg  <= data_credit_i;
                            inf_h_reg <= (hdr_credit_i == 6'd0);
                            inf_d_reg <= (data_credit_i == 12'd0);
                        end else begin
                            if (!inf_h_reg) cl_h_reg <= hdr_credit_i;
                            if (!inf_d_reg) cl_d_reg <= data_credit_i;
                        end
                    end
                    // Consumption is independent of the limit update; both may
                    // land on the same edge. Infinite fields keep CC at zero.
                    if (consume[gi]) begin
                        if (!inf_h_reg) cc_h_reg <= cc_h_reg + 6'd1;
                        if (!inf_d_reg) cc_d_reg <= cc_d_reg + req_d;
                    end
                end
            end
        end
    endgenerate

    // Type 11 never qualifies for a grant.
    assign suff_all = {1'b0, suff};

    always_comb begin
        state_next = state_reg;
        gnt_next   = 1'b0;
        err_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (tlp_req_i) begin
                    if (tlp_type_i == 2'b11) begin
                        err_next   = 1'b1;
                        state_next = HOLD;
                    end else if (suff_all[tlp_type_i]) begin
                        gnt_next   = 1'b1;
                        state_next = HOLD;
                    end
                end
            end
            // One dead cycle lets the requester drop or replace its request.
            HOLD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            gnt_reg   <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            gnt_reg   <= gnt_next;
            err_reg   <= err_next;
        end
    end

    assign tlp_gnt_o = gnt_reg;
    assign tlp_err_o = err_reg;
    assign fc_init_o = init_vec;

endmodule

// File: tb/tb_dll_tx_fc_credit_gate.sv
// -----------------------------------------------------------------------------
// tb_dll_tx_fc_credit_gate
//
// Directed bench for the TX flow-control credit gate. Each clock step pushes
// the expected {err, gnt} for the inputs just driven into a scoreboard queue;
// after the edge the entry is popped and compared with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_dll_tx_fc_credit_gate;

    logic        clk = 1'b0;
    logic        rst;
    logic        updatefc;
    logic [1:0]  fc_type;
    logic [5:0]  hdr_credit;
    logic [11:0] data_credit;
    logic        tlp_req;
    logic [1:0]  tlp_type;
    logic        tlp_has_data;
    logic [9:0]  tlp_len;
    logic        tlp_gnt;
    logic        tlp_err;
    logic [2:0]  fc_init;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] v;
        string      tag;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    dll_tx_fc_credit_gate dut (
        .clk            (clk),
        .rst            (rst),
        .updatefc_i     (updatefc),
        .fc_type_i      (fc_type),
        .hdr_credit_i   (hdr_credit),
        .data_credit_i  (data_credit),
        .tlp_req_i      (tlp_req),
        .tlp_type_i     (tlp_type),
        .tlp_has_data_i (tlp_has_data),
        .tlp_len_i      (tlp_len),
        .tlp_gnt_o      (tlp_gnt),
        .tlp_err_o      (tlp_err),
        .fc_init_o      (fc_init)
    );

    // One clock: expected {err,gnt} for the current inputs is queued, then
    // popped and compared #1 after the edge. The UpdateFC strobe lasts one cycle.
    task automatic step(input logic eg, input logic ee, input string tag);
        exp_t e;
        e.v   = {ee, eg};
        e.tag = tag;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        updatefc = 1'b0;
        e = exp_q.pop_front();
        checks++;
        assert ({tlp_err, tlp_gnt} === e.v)
        else begin
            errors++;
            $error("FAIL %s: observed err,gnt=%b expected %b", e.tag, {tlp_err, tlp_gnt}, e.v);
        end
        $display("step %-14s err,gnt=%b exp=%b", e.tag, {tlp_err, tlp_gnt}, e.v);
    endtask

    task automatic check_init(input logic [2:0] exp_v, input string tag);
        checks++;
        assert (fc_init === exp_v)
        else begin
            errors++;
            $error("FAIL %s: observed fc_init=%b expected %b", tag, fc_init, exp_v);
        end
        $display("init %-14s fc_init=%b exp=%b", tag, fc_init, exp_v);
    endtask

    task automatic upd(input logic [1:0] ft, input logic [5:0] h, input logic [11:0] d);
        updatefc    = 1'b1;
        fc_type     = ft;
        hdr_credit  = h;
        data_credit = d;
    endtask

    task automatic req(input logic [1:0] tt, input logic hd, input logic [9:0] ln);
        tlp_req      = 1'b1;
        tlp_type     = tt;
        tlp_has_data = hd;
        tlp_len      = ln;
    endtask

    // Grant followed by the mandatory dead cycle; the request stays high in
    // the dead cycle so a back-to-back grant would be caught.
    task automatic grant_pair(input string tag);
        step(1'b1, 1'b0, tag);
        step(1'b0, 1'b0, {tag, "_hold"});
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        step(1'b0, 1'b0, tag);
        rst = 1'b0;
        check_init(3'b000, {tag, "_init"});
    endtask

    initial begin
        rst = 1'b1; updatefc = 1'b0; fc_type = 2'd0; hdr_credit = 6'd0;
        data_credit = 12'd0; tlp_req = 1'b0; tlp_type = 2'd0;
        tlp_has_data = 1'b0; tlp_len = 10'd0;

        // --- reset, request before any UpdateFC ---
        do_reset("reset");
        req(2'd0, 1'b0, 10'd0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, $sformatf("noinit_%0d", i));
        upd(2'd0, 6'd4, 12'd16);
        step(1'b0, 1'b0, "first_upd");      // first UpdateFC never grants same cycle
        check_init(3'b001, "init_p");
        step(1'b1, 1'b0, "p_first_gnt");
        tlp_req = 1'b0;
        step(1'b0, 1'b0, "p_first_hold");

        // --- P header limit 2, then 4 ---
        do_reset("reset2");
        upd(2'd0, 6'd2, 12'd16);
        step(1'b0, 1'b0, "p_upd2");
        req(2'd0, 1'b0, 10'd0);
        grant_pair("p_g1");
        grant_pair("p_g2");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, $sformatf("p_held_%0d", i));
        upd(2'd0, 6'd4, 12'd16);
        step(1'b0, 1'b0, "p_upd4_same");    // check uses the old limit
        grant_pair("p_g3");
        grant_pair("p_g4");
        step(1'b0, 1'b0, "p_held_end");
        tlp_req = 1'b0;

        // --- NP data credits, ceil and len=0 ---
        upd(2'd1, 6'd8, 12'd16);
        step(1'b0, 1'b0, "np_upd16");
        req(2'd1, 1'b1, 10'd33);
        grant_pair("np_len33_a");          // 9 credits of 16
        step(1'b0, 1'b0, "np_len33_held");  // 18 > 16
        step(1'b0, 1'b0, "np_len33_held2");
        upd(2'd1, 6'd8, 12'd32);
        step(1'b0, 1'b0, "np_upd32_same");
        grant_pair("np_len33_b");
        tlp_req = 1'b0;
        upd(2'd1, 6'd8, 12'd300);
        step(1'b0, 1'b0, "np_upd300");
        req(2'd1, 1'b1, 10'd0);
        grant_pair("np_len0_a");           // CC_d 18 -> 274
        step(1'b0, 1'b0, "np_len0_held");
        upd(2'd1, 6'd8, 12'd529);
        step(1'b0, 1'b0, "np_upd529");
        step(1'b0, 1'b0, "np_short1");      // one credit short of 256
        upd(2'd1, 6'd8, 12'd530);
        step(1'b0, 1'b0, "np_upd530");
        grant_pair("np_len0_b");
        tlp_req = 1'b0;

        // --- CPL infinite ---
        upd(2'd2, 6'd0, 12'd0);
        step(1'b0, 1'b0, "cpl_upd_inf");
        check_init(3'b111, "init_all");
        req(2'd2, 1'b1, 10'd0);
        for (int i = 0; i < 100; i++) grant_pair($sformatf("cpl_%0d", i));
        tlp_req = 1'b0;
        upd(2'd2, 6'd5, 12'd5);
        step(1'b0, 1'b0, "cpl_upd5");
        req(2'd2, 1'b1, 10'd0);
        for (int i = 0; i < 8; i++) grant_pair($sformatf("cpl_inf_%0d", i));
        tlp_req = 1'b0;

        // --- half-range boundary and header wrap ---
        do_reset("reset3");
        upd(2'd0, 6'd34, 12'd0);
        req(2'd0, 1'b0, 10'd0);
        step(1'b0, 1'b0, "w_upd34");
        step(1'b0, 1'b0, "w_diff33");       // 33 ahead reads as overdraw
        upd(2'd0, 6'd33, 12'd0);
        step(1'b0, 1'b0, "w_upd33_same");
        grant_pair("w_diff32");            // exactly 32 ahead is allowed
        for (int i = 0; i < 32; i++) grant_pair($sformatf("w_a%0d", i));
        step(1'b0, 1'b0, "w_held33");
        upd(2'd0, 6'd60, 12'd0);
        step(1'b0, 1'b0, "w_upd60");
        for (int i = 0; i < 27; i++) grant_pair($sformatf("w_b%0d", i));
        step(1'b0, 1'b0, "w_held60");
        upd(2'd0, 6'd62, 12'd0);
        step(1'b0, 1'b0, "w_upd62");
        for (int i = 0; i < 2; i++) grant_pair($sformatf("w_c%0d", i));
        step(1'b0, 1'b0, "w_held62");
        upd(2'd0, 6'd2, 12'd0);
        step(1'b0, 1'b0, "w_upd2");
        for (int i = 0; i < 4; i++) grant_pair($sformatf("w_d%0d", i));
        step(1'b0, 1'b0, "w_held2");
        upd(2'd0, 6'd4, 12'd0);
        step(1'b0, 1'b0, "w_upd4");
        for (int i = 0; i < 2; i++) grant_pair($sformatf("w_e%0d", i));
        step(1'b0, 1'b0, "w_held4");

        // --- illegal type ---
        req(2'd3, 1'b0, 10'd0);
        step(1'b0, 1'b1, "illegal_err");
        tlp_req = 1'b0;
        step(1'b0, 1'b0, "illegal_hold");
        upd(2'd0, 6'd5, 12'd0);
        step(1'b0, 1'b0, "w_upd5");
        req(2'd0, 1'b0, 10'd0);
        grant_pair("after_err");           // only one credit: CC untouched by error
        step(1'b0, 1'b0, "after_err_held");

        // --- reset with a waiting request ---
        rst = 1'b1;
        step(1'b0, 1'b0, "rst_mid_req");
        rst = 1'b0;
        check_init(3'b000, "rst_mid_init");
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, $sformatf("post_rst_%0d", i));
        check_init(3'b000, "post_rst_init");
        upd(2'd0, 6'd1, 12'd0);
        step(1'b0, 1'b0, "reinit_same");
        grant_pair("reinit_gnt");
        tlp_req = 1'b0;
        check_init(3'b001, "reinit_init");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dll_tx_fc_credit_gate.md
# dll_tx_fc_credit_gate

Transmit-side flow-control credit gate for the data link layer. It consumes the decoded UpdateFC stream produced by the receive DLLP checker: strobe, FC type, 6-bit header credits and 12-bit data credits. From that stream it keeps per-type credit limits, tracks credits consumed by outgoing TLPs, and grants a TLP request only when the link partner has advertised enough header and data credit. It sits between the transaction-layer TX arbiter and the DLL TX framer.

## Interface
- No parameters. Widths are fixed: header field 6 bits (modulo 64), data field 12 bits (modulo 4096).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- updatefc_i  in  1  one-cycle strobe: valid UpdateFC decoded
- fc_type_i  in  2  00=P, 01=NP, 10=CPL; 11 ignored
- hdr_credit_i  in  6  advertised header credit limit
- data_credit_i  in  12  advertised data credit limit
- tlp_req_i  in  1  TLP waiting for grant; held until grant or error
- tlp_type_i  in  2  00=P, 01=NP, 10=CPL, 11=illegal
- tlp_has_data_i  in  1  TLP carries payload
- tlp_len_i  in  10  payload length in DW; 0 means 1024
- tlp_gnt_o  out  1  one-cycle grant; credits consumed on the same edge
- tlp_err_o  out  1  one-cycle pulse: request with tlp_type_i=11 rejected
- fc_init_o  out  3  bit t set once type t has received its first UpdateFC

## Operation
- Per-type state for t in {P, NP, CPL}:
  - init flag
  - CL_h (6 b), CL_d (12 b)
  - CC_h (6 b), CC_d (12 b)
  - inf_h, inf_d
- First UpdateFC for type t (init=0):
  - CL_h=hdr_credit_i and CL_d=data_credit_i
  - inf_h=(hdr_credit_i==0), inf_d=(data_credit_i==0)
  - init←1
- Later UpdateFC for type t:
  - CL_h overwritten unless inf_h; CL_d overwritten unless inf_d.
  - Infinite status never changes after init.
- fc_type_i=11 with updatefc_i: no state change.
- Required credits per request:
  - Header: 1 (PH).
  - Data: 0 if !tlp_has_data_i; otherwise ceil(len/4) = (len+3)>>2 in 11-bit arithmetic, with len=0 giving 256.
- Sufficiency for field F of width N:
  - inf_F, or
  - ((CL_F − (CC_F + req_F)) mod 2^N) ≤ 2^(N−1), i.e. ≤ 32 for header, ≤ 2048 for data.
- Both header and data fields must pass, and init must be 1 for the type.
- FSM with two states, IDLE and HOLD:
  - IDLE, tlp_req_i, type 11 → tlp_err_o=1 next cycle, state → HOLD.
  - IDLE, tlp_req_i, init and sufficient → tlp_gnt_o=1 next cycle. CC_h += 1 and CC_d += req_d (modular) on that edge. State → HOLD.
  - IDLE, otherwise → stay; the request waits with no timeout.
  - HOLD → IDLE unconditionally. No grant or error is issued in HOLD, so grants are never back-to-back. The requester drops or replaces tlp_req_i in the cycle tlp_gnt_o/tlp_err_o is high.
- CC counters are not updated for infinite fields (held at 0).

## Timing
- Reset (rst=1 at posedge): all CL, CC, init and inf cleared; state=IDLE; tlp_gnt_o=0, tlp_err_o=0, fc_init_o=000.
- A reset mid-request discards the request; nothing is granted until after re-init.
- Latency:
  - Request sampled in cycle n → tlp_gnt_o/tlp_err_o in cycle n+1.
  - Maximum one grant per 2 cycles.
- Simultaneous UpdateFC and request for the same type in cycle n:
  - The check uses CL values registered before n.
  - The new CL takes effect from n+1.
  - The first UpdateFC does not enable a grant in the same cycle.
- UpdateFC and a grant may update the same type's CL and CC on the same edge; both updates apply.
- fc_init_o bit asserts the cycle after the first UpdateFC for that type.
- Wrap-around: CC and CL roll modulo 64 / 4096 with no saturation. The mod-compare handles the wrap.

## Test plan
- Reset, then request P with no data → no grant for 20 cycles. UpdateFC P hdr=4 data=16 → fc_init_o=001; the grant arrives 1 cycle after the next request sample.
- P hdr=2, four no-data requests → exactly 2 grants. UpdateFC hdr=4 → 2 more grants. Grants never in consecutive cycles.
- NP data=16, request len=33 DW (9 credits) → grant; second len=33 → held. UpdateFC data=32 → grant. Len=0 with data=300 → requires 256 credits.
- Init CPL with hdr=0 data=0 (infinite) → 100 requests of len=1024 all granted. Later UpdateFC CPL hdr=5 → still infinite.
- Wrap: P hdr limit stepped via UpdateFC 60, 62, 2, 4 while granting → CC_h wraps past 63 and grants track limits exactly. tlp_type=11 → tlp_err_o pulse, no grant, no CC change.
- Request waiting when rst pulses → no grant afterward. fc_init_o=000 and tlp_gnt_o=0 until re-init.
